// File: rtl/mem_access.sv
// MEM stage of the THCOMIPS32e pipeline: req/ack bus access for loads/stores,
// load-data formatting and MEM/WB write-back fields.
module mem_access #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq_mem_o,
    output logic        addr_err_o,
    output logic        bus_err_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] OP_LB  = 8'hE0;
    localparam logic [7:0] OP_LH  = 8'hE1;
    localparam logic [7:0] OP_LW  = 8'hE3;
    localparam logic [7:0] OP_LBU = 8'hE4;
    localparam logic [7:0] OP_LHU = 8'hE5;
    localparam logic [7:0] OP_SB  = 8'hE8;
    localparam logic [7:0] OP_SH  = 8'hE9;
    localparam logic [7:0] OP_SW  = 8'hEB;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [7:0]    op_q;
    logic [1:0]    lane_q;
    logic          load_q, fault_q, flushed_q;
    logic [31:0]   rdata_q;

    logic          is_load, is_store, is_mem, misaligned, timeout;
    logic          is_byte, is_half;
    logic [3:0]    be_c;
    logic [31:0]   st_wdata_c, fmt_c;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;

    // Decode of the incoming EX/MEM operation
    always_comb begin
        is_load  = (aluop_i == OP_LB) || (aluop_i == OP_LH) || (aluop_i == OP_LW) ||
                   (aluop_i == OP_LBU) || (aluop_i == OP_LHU);
        is_store = (aluop_i == OP_SB) || (aluop_i == OP_SH) || (aluop_i == OP_SW);
        is_mem   = is_load || is_store;
        is_byte  = (aluop_i == OP_LB) || (aluop_i == OP_LBU) || (aluop_i == OP_SB);
        is_half  = (aluop_i == OP_LH) || (aluop_i == OP_LHU) || (aluop_i == OP_SH);
        misaligned = (is_half && mem_addr_i[0]) ||
                     (((aluop_i == OP_LW) || (aluop_i == OP_SW)) && (mem_addr_i[1:0] != 2'b00));
        if (is_byte)      be_c = 4'b0001 << mem_addr_i[1:0];
        else if (is_half) be_c = mem_addr_i[1] ? 4'b1100 : 4'b0011;
        else              be_c = 4'b1111;
        if (is_byte)      st_wdata_c = {4{reg2_i[7:0]}};
        else if (is_half) st_wdata_c = {2{reg2_i[15:0]}};
        else              st_wdata_c = reg2_i;
        timeout = (cnt == CW'(TIMEOUT_CYCLES - 1)) && !bus_ack_i;
    end

    // Lane selection and extension of the captured load word
    always_comb begin
        case (lane_q)
            2'd0:    lane_b = rdata_q[7:0];
            2'd1:    lane_b = rdata_q[15:8];
            2'd2:    lane_b = rdata_q[23:16];
            default: lane_b = rdata_q[31:24];
        endcase
        lane_h = lane_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (op_q)
            OP_LB:   fmt_c = {{24{lane_b[7]}}, lane_b};
            OP_LBU:  fmt_c = {24'd0, lane_b};
            OP_LH:   fmt_c = {{16{lane_h[15]}}, lane_h};
            OP_LHU:  fmt_c = {16'd0, lane_h};
            default: fmt_c = rdata_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (is_mem && !flush_i) state_nxt = misaligned ? ST_DONE : ST_WAIT;
            ST_WAIT: if (bus_ack_i || timeout) state_nxt = ST_DONE;
            ST_DONE: if (flush_i || !stall_i) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Write-back fields and stall request; forced low while in reset
    always_comb begin
        wd_o           = 5'd0;
        wreg_o         = 1'b0;
        wdata_o        = 32'd0;
        stallreq_mem_o = 1'b0;
        if (!rst) begin
            wd_o = wd_i;
            case (state)
                ST_IDLE: begin
                    wdata_o        = wdata_i;
                    wreg_o         = wreg_i && !is_mem && !flush_i;
                    stallreq_mem_o = is_mem && !flush_i;
                end
                ST_WAIT: begin
                    wdata_o        = wdata_i;
                    stallreq_mem_o = 1'b1;
                end
                ST_DONE: begin
                    wdata_o = load_q ? fmt_c : wdata_i;
                    wreg_o  = wreg_i && load_q && !fault_q && !flushed_q && !flush_i;
                end
                default: ;
            endcase
        end
    end

    // Bus request, timeout counter and per-access bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= 32'd0;
            bus_be_o    <= 4'd0;
            bus_wdata_o <= 32'd0;
            addr_err_o  <= 1'b0;
            bus_err_o   <= 1'b0;
            cnt         <= '0;
            op_q        <= 8'd0;
            lane_q      <= 2'd0;
            load_q      <= 1'b0;
            fault_q     <= 1'b0;
            flushed_q   <= 1'b0;
            rdata_q     <= 32'd0;
        end else begin
            addr_err_o <= 1'b0;
            bus_err_o  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cnt       <= '0;
                    fault_q   <= 1'b0;
                    flushed_q <= 1'b0;
                    if (is_mem && !flush_i) begin
                        op_q   <= aluop_i;
                        lane_q <= mem_addr_i[1:0];
                        load_q <= is_load;
                        if (misaligned) begin
                            addr_err_o <= 1'b1;
                            fault_q    <= 1'b1;
                        end else begin
                            bus_req_o   <= 1'b1;
                            bus_we_o    <= is_store;
                            bus_addr_o  <= {mem_addr_i[31:2], 2'b00};
                            bus_be_o    <= be_c;
                            bus_wdata_o <= st_wdata_c;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (flush_i) flushed_q <= 1'b1;
                    if (bus_ack_i) begin
                        rdata_q   <= bus_rdata_i;
                        bus_req_o <= 1'b0;
                    end else if (timeout) begin
                        bus_req_o <= 1'b0;
                        fault_q   <= 1'b1;
                        bus_err_o <= !(flushed_q || flush_i);
                    end
                end
                ST_DONE: if (flush_i) flushed_q <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: stimulus queues expected access results,
// a negedge monitor pops them when the stall request releases.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  aluop_i = 8'h00;
    logic [31:0] mem_addr_i = 32'd0, reg2_i = 32'd0, wdata_i = 32'd0, bus_rdata_i = 32'd0;
    logic [4:0]  wd_i = 5'd0;
    logic        wreg_i = 1'b0, stall_i = 1'b0, flush_i = 1'b0, bus_ack_i = 1'b0;
    logic        bus_req_o, bus_we_o, wreg_o, stallreq_mem_o, addr_err_o, bus_err_o;
    logic [31:0] bus_addr_o, bus_wdata_o, wdata_o;
    logic [3:0]  bus_be_o;
    logic [4:0]  wd_o;

    mem_access #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i),
        .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .stall_i(stall_i), .flush_i(flush_i), .bus_rdata_i(bus_rdata_i),
        .bus_ack_i(bus_ack_i), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
        .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .stallreq_mem_o(stallreq_mem_o), .addr_err_o(addr_err_o), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        bus;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] bwdata;
        int          req_cyc;
        int          stall_cyc;
        logic        wreg;
        logic        chk_wd;
        logic [31:0] wdata;
        logic        aerr;
        logic        berr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0, failures = 0;
    int   exp_rises = 0, exp_aerr = 0, exp_berr = 0;
    int   req_rises = 0, aerr_total = 0, berr_total = 0;
    int   slave_delay = 0;
    logic [31:0] slave_rdata = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic bus, input logic we, input logic [31:0] addr,
                                input logic [3:0] be, input logic [31:0] bwdata, input int rc,
                                input int sc, input logic wreg, input logic chk_wd,
                                input logic [31:0] wdata, input logic aerr, input logic berr);
        exp_t e;
        e.bus = bus; e.we = we; e.addr = addr; e.be = be; e.bwdata = bwdata;
        e.req_cyc = rc; e.stall_cyc = sc; e.wreg = wreg; e.chk_wd = chk_wd;
        e.wdata = wdata; e.aerr = aerr; e.berr = berr;
        return e;
    endfunction

    // Bus slave: acks in the slave_delay-th cycle of a request (0 = never)
    initial begin
        int wn;
        wn = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bus_req_o) begin
                wn++;
                bus_ack_i   = (slave_delay != 0) && (wn == slave_delay);
                bus_rdata_i = slave_rdata;
            end else begin
                wn = 0;
                bus_ack_i = 1'b0;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        logic        prev_stall, prev_req, held_active, cap_we;
        logic [31:0] held_val, cap_addr, cap_wdata;
        logic [3:0]  cap_be;
        int          stall_cnt, req_cnt;
        exp_t        e;
        prev_stall = 0; prev_req = 0; held_active = 0; held_val = 0;
        cap_we = 0; cap_addr = 0; cap_wdata = 0; cap_be = 0;
        stall_cnt = 0; req_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0; prev_req = 0; held_active = 0;
                stall_cnt = 0; req_cnt = 0;
            end else begin
                if (held_active) begin
                    if (stall_i) chk("held_wdata", wdata_o, held_val);
                    else held_active = 0;
                end
                if (addr_err_o) aerr_total++;
                if (bus_err_o) berr_total++;
                if (bus_req_o) begin
                    req_cnt++;
                    if (!prev_req) begin
                        req_rises++;
                        cap_we = bus_we_o; cap_addr = bus_addr_o;
                        cap_be = bus_be_o; cap_wdata = bus_wdata_o;
                    end
                end
                if (stallreq_mem_o) stall_cnt++;
                else if (prev_stall) begin
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_completion actual=1 required=0");
                    end else begin
                        e = exp_q.pop_front();
                        chk("stall_cycles", 32'(stall_cnt), 32'(e.stall_cyc));
                        chk("req_cycles", 32'(req_cnt), 32'(e.req_cyc));
                        chk("wreg_o", 32'(wreg_o), 32'(e.wreg));
                        chk("addr_err_o", 32'(addr_err_o), 32'(e.aerr));
                        chk("bus_err_o", 32'(bus_err_o), 32'(e.berr));
                        if (e.chk_wd) chk("wdata_o", wdata_o, e.wdata);
                        if (e.bus) begin
                            chk("bus_we_o", 32'(cap_we), 32'(e.we));
                            chk("bus_addr_o", cap_addr, e.addr);
                            chk("bus_be_o", 32'(cap_be), 32'(e.be));
                            if (e.we) chk("bus_wdata_o", cap_wdata, e.bwdata);
                        end
                        held_active = e.chk_wd;
                        held_val = e.wdata;
                    end
                    stall_cnt = 0;
                    req_cnt = 0;
                end
                prev_stall = stallreq_mem_o;
                prev_req = bus_req_o;
            end
        end
    end

    task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                          input logic [31:0] rdata, input int ack_d, input int hold,
                          input int flush_at, input exp_t e);
        int n;
        exp_q.push_back(e);
        if (e.bus) exp_rises++;
        if (e.aerr) exp_aerr++;
        if (e.berr) exp_berr++;
        slave_delay = ack_d;
        slave_rdata = rdata;
        @(posedge clk); #1;
        aluop_i = op; mem_addr_i = addr; reg2_i = reg2;
        wreg_i = 1'b1; wd_i = 5'd7; wdata_i = 32'h1111_2222;
        n = 0;
        forever begin
            @(posedge clk); #1;
            n++;
            if (!stallreq_mem_o) break;
            flush_i = (flush_at != 0) && (n == flush_at);
            if (n > 100) begin
                checks++; failures++;
                $display("FAIL access_timeout actual=%0d required<=100", n);
                break;
            end
        end
        flush_i = 1'b0;
        stall_i = (hold > 0);
        repeat (hold) begin @(posedge clk); #1; end
        stall_i = 1'b0;
        @(posedge clk); #1;
        aluop_i = 8'h00; wreg_i = 1'b0;
    endtask

    initial begin
        // Reset: outputs zero even with a live non-memory op on the inputs
        aluop_i = 8'h21; wd_i = 5'd3; wreg_i = 1'b1; wdata_i = 32'h1234_5678;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wreg_o", 32'(wreg_o), 32'd0);
        chk("rst_wdata_o", wdata_o, 32'd0);
        chk("rst_wd_o", 32'(wd_o), 32'd0);
        chk("rst_bus_req_o", 32'(bus_req_o), 32'd0);
        rst = 1'b0;
        #1;
        chk("pt_wd_o", 32'(wd_o), 32'd3);
        chk("pt_wreg_o", 32'(wreg_o), 32'd1);
        chk("pt_wdata_o", wdata_o, 32'h1234_5678);
        chk("pt_stallreq", 32'(stallreq_mem_o), 32'd0);
        flush_i = 1'b1;
        #1;
        chk("pt_flush_wreg_o", 32'(wreg_o), 32'd0);
        flush_i = 1'b0; aluop_i = 8'h00; wreg_i = 1'b0;

        run_op(8'hE3, 32'h8000_0010, 32'd0, 32'hDEAD_BEEF, 2, 0, 0,
               mk(1, 0, 32'h8000_0010, 4'hF, 32'd0, 2, 3, 1, 1, 32'hDEAD_BEEF, 0, 0));
        run_op(8'hE0, 32'h8000_0013, 32'd0, 32'h80FF_1234, 1, 0, 0,
               mk(1, 0, 32'h8000_0010, 4'h8, 32'd0, 1, 2, 1, 1, 32'hFFFF_FF80, 0, 0));
        run_op(8'hE4, 32'h8000_0013, 32'd0, 32'h80FF_1234, 1, 0, 0,
               mk(1, 0, 32'h8000_0010, 4'h8, 32'd0, 1, 2, 1, 1, 32'h0000_0080, 0, 0));
        run_op(8'hE9, 32'h0000_1002, 32'h0000_ABCD, 32'd0, 1, 0, 0,
               mk(1, 1, 32'h0000_1000, 4'hC, 32'hABCD_ABCD, 1, 2, 0, 0, 32'd0, 0, 0));
        run_op(8'hE8, 32'h0000_2001, 32'h0000_005A, 32'd0, 3, 0, 0,
               mk(1, 1, 32'h0000_2000, 4'h2, 32'h5A5A_5A5A, 3, 4, 0, 0, 32'd0, 0, 0));
        run_op(8'hE1, 32'h0000_3002, 32'd0, 32'h80FF_1234, 1, 0, 0,
               mk(1, 0, 32'h0000_3000, 4'hC, 32'd0, 1, 2, 1, 1, 32'hFFFF_80FF, 0, 0));
        run_op(8'hE3, 32'h0000_4002, 32'd0, 32'd0, 1, 0, 0,
               mk(0, 0, 32'd0, 4'h0, 32'd0, 0, 1, 0, 0, 32'd0, 1, 0));
        run_op(8'hE1, 32'h0000_4001, 32'd0, 32'd0, 1, 0, 0,
               mk(0, 0, 32'd0, 4'h0, 32'd0, 0, 1, 0, 0, 32'd0, 1, 0));
        run_op(8'hE3, 32'h0000_0100, 32'd0, 32'd0, 0, 0, 0,
               mk(1, 0, 32'h0000_0100, 4'hF, 32'd0, 16, 17, 0, 0, 32'd0, 0, 1));
        run_op(8'hE3, 32'h0000_0044, 32'd0, 32'h1357_9BDF, 1, 3, 0,
               mk(1, 0, 32'h0000_0044, 4'hF, 32'd0, 1, 2, 1, 1, 32'h1357_9BDF, 0, 0));
        run_op(8'hE3, 32'h0000_0048, 32'd0, 32'h2468_ACE0, 3, 0, 1,
               mk(1, 0, 32'h0000_0048, 4'hF, 32'd0, 3, 4, 0, 0, 32'd0, 0, 0));
        run_op(8'hEB, 32'h0000_0020, 32'hCAFE_F00D, 32'd0, 1, 0, 0,
               mk(1, 1, 32'h0000_0020, 4'hF, 32'hCAFE_F00D, 1, 2, 0, 0, 32'd0, 0, 0));

        // Reset in the middle of a pending access
        slave_delay = 0;
        @(posedge clk); #1;
        aluop_i = 8'hE3; mem_addr_i = 32'h0000_0040; wreg_i = 1'b1; wd_i = 5'd9;
        exp_rises++;
        repeat (3) begin @(posedge clk); #1; end
        chk("req_before_rst", 32'(bus_req_o), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_bus_req_o", 32'(bus_req_o), 32'd0);
        chk("midrst_stallreq", 32'(stallreq_mem_o), 32'd0);
        chk("midrst_bus_addr_o", bus_addr_o, 32'd0);
        chk("midrst_wd_o", 32'(wd_o), 32'd0);
        aluop_i = 8'h00; wreg_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        run_op(8'hE5, 32'h8000_0000, 32'd0, 32'h80FF_1234, 2, 0, 0,
               mk(1, 0, 32'h8000_0000, 4'h3, 32'd0, 2, 3, 1, 1, 32'h0000_1234, 0, 0));

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("req_transactions", 32'(req_rises), 32'(exp_rises));
        chk("addr_err_pulses", 32'(aerr_total), 32'(exp_aerr));
        chk("bus_err_pulses", 32'(berr_total), 32'(exp_berr));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
